// File: rtl/truth_table_sweeper_if.sv
// Control, golden-table and function-under-test signals between a sweeper and its environment.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned TW = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [TW-1:0]   expected;
  logic            y;
  logic [N_IN-1:0] x;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
  logic            fail;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, abort, expected, y,
    input  x, busy, done, table_out, fail, first_fail
  );

  modport slave (
    input  start, abort, expected, y,
    output x, busy, done, table_out, fail, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every N_IN-bit input vector through an external function, captures its
// 1-bit output into a truth table and compares against a golden table.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int unsigned TW = 1 << N_IN;
  localparam logic [N_IN-1:0] X_LAST = N_IN'(TW - 1);
  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t          state, state_next;
  logic [N_IN-1:0] x_q, x_next;
  logic [7:0]      cnt, cnt_next;
  logic [TW-1:0]   tbl_q, tbl_next;
  logic            fail_q, fail_next;
  logic [N_IN-1:0] ff_q, ff_next;
  logic            busy_q, busy_next;
  logic            done_q, done_next;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      x_q    <= '0;
      cnt    <= '0;
      tbl_q  <= '0;
      fail_q <= 1'b0;
      ff_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      x_q    <= x_next;
      cnt    <= cnt_next;
      tbl_q  <= tbl_next;
      fail_q <= fail_next;
      ff_q   <= ff_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    x_next     = x_q;
    cnt_next   = cnt;
    tbl_next   = tbl_q;
    fail_next  = fail_q;
    ff_next    = ff_q;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = S_SETTLE;
          x_next     = '0;
          cnt_next   = CNT_INIT;
          tbl_next   = '0;
          fail_next  = 1'b0;
          ff_next    = '0;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_next = S_IDLE;
        end else if (cnt == 8'd0) begin
          state_next = S_SAMPLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          state_next = S_IDLE;
        end else begin
          tbl_next[x_q] = bus.y;
          // Ascending sweep: the first mismatch seen is the lowest index
          if ((bus.y != bus.expected[x_q]) && !fail_q) begin
            fail_next = 1'b1;
            ff_next   = x_q;
          end
          if (x_q == X_LAST) begin
            state_next = S_DONE;
          end else begin
            x_next     = x_q + N_IN'(1);
            cnt_next   = CNT_INIT;
            state_next = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next == S_SETTLE) || (state_next == S_SAMPLE);
    // done is registered off the DONE state, so it lands one edge after DONE entry
    done_next = (state == S_DONE);
  end

  assign bus.x          = x_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_out  = tbl_q;
  assign bus.fail       = fail_q;
  assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed checks of truth_table_sweeper with N_IN=3, SETTLE=2 driving small reference functions.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst;
  logic mode;   // 0: majority, 1: 3-input xor
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat;
  logic saw_done;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) bus ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Function under test, purely combinational on x
  always_comb begin
    if (mode)
      bus.y = bus.x[0] ^ bus.x[1] ^ bus.x[2];
    else
      bus.y = (bus.x[0] & bus.x[1]) | (bus.x[0] & bus.x[2]) | (bus.x[1] & bus.x[2]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sweep(input logic [7:0] exp_tbl, input logic md);
    bus.expected = exp_tbl;
    mode         = md;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Edges from the current point until done is seen; -1 if it never comes
  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic wait_x(input logic [2:0] v);
    for (int k = 0; k < 40; k++) begin
      if (bus.x === v) break;
      tick();
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.expected = 8'h00;
    mode         = 1'b0;
    #12;
    check("reset_x",     32'(bus.x), 32'h0);
    check("reset_busy",  32'(bus.busy), 32'h0);
    check("reset_done",  32'(bus.done), 32'h0);
    check("reset_table", 32'(bus.table_out), 32'h0);
    check("reset_fail",  32'(bus.fail), 32'h0);
    check("reset_ff",    32'(bus.first_fail), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Majority, matching golden table
    begin_sweep(8'hE8, 1'b0);
    wait_done(lat);
    check("maj_latency", 32'(lat), 32'd25);
    check("maj_table",   32'(bus.table_out), 32'hE8);
    check("maj_fail",    32'(bus.fail), 32'h0);
    check("maj_ff",      32'(bus.first_fail), 32'h0);
    check("maj_busy",    32'(bus.busy), 32'h0);
    tick();
    check("maj_done_pulse", 32'(bus.done), 32'h0);

    // XOR, verifying each vector is held for three cycles
    begin_sweep(8'h96, 1'b1);
    check("xor_busy0", 32'(bus.busy), 32'h1);
    check("xor_x0",    32'(bus.x), 32'h0);
    for (int j = 1; j < 24; j++) begin
      tick();
      check($sformatf("xor_x_e%0d", j), 32'(bus.x), 32'(j / 3));
    end
    check("xor_busy23", 32'(bus.busy), 32'h1);
    wait_done(lat);
    check("xor_latency", 32'(lat), 32'd2);
    check("xor_table",   32'(bus.table_out), 32'h96);
    check("xor_fail",    32'(bus.fail), 32'h0);

    // Mismatching golden tables
    begin_sweep(8'hE9, 1'b0);
    wait_done(lat);
    check("e9_table", 32'(bus.table_out), 32'hE8);
    check("e9_fail",  32'(bus.fail), 32'h1);
    check("e9_ff",    32'(bus.first_fail), 32'h0);
    begin_sweep(8'hEC, 1'b0);
    wait_done(lat);
    check("ec_fail", 32'(bus.fail), 32'h1);
    check("ec_ff",   32'(bus.first_fail), 32'h2);
    begin_sweep(8'h28, 1'b0);
    wait_done(lat);
    check("28_ff",   32'(bus.first_fail), 32'h6);
    repeat (3) tick();
    check("28_ff_hold_idle", 32'(bus.first_fail), 32'h6);

    // Abort at x=4
    begin_sweep(8'hE8, 1'b0);
    wait_x(3'd4);
    check("abort_at_x", 32'(bus.x), 32'h4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy",  32'(bus.busy), 32'h0);
    check("abort_table", 32'(bus.table_out), 32'h08);
    check("abort_x",     32'(bus.x), 32'h4);
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      saw_done = saw_done | bus.done;
    end
    check("abort_no_done",      32'(saw_done), 32'h0);
    check("abort_table_stable", 32'(bus.table_out), 32'h08);

    // start and abort together in IDLE: stay idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy",  32'(bus.busy), 32'h0);
    check("start_abort_table", 32'(bus.table_out), 32'h08);

    // Async reset mid-SETTLE at x=5
    begin_sweep(8'hE9, 1'b0);
    wait_x(3'd5);
    check("rst_pre_x",    32'(bus.x), 32'h5);
    check("rst_pre_fail", 32'(bus.fail), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_x",     32'(bus.x), 32'h0);
    check("rst_async_table", 32'(bus.table_out), 32'h0);
    check("rst_async_fail",  32'(bus.fail), 32'h0);
    check("rst_async_busy",  32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();
    begin_sweep(8'hE8, 1'b0);
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd25);
    check("post_rst_table",   32'(bus.table_out), 32'hE8);

    // start held high: back-to-back sweeps
    bus.expected = 8'h96;
    mode         = 1'b1;
    bus.start    = 1'b1;
    tick();
    wait_done(lat);
    check("held_latency1", 32'(lat), 32'd25);
    check("held_table1",   32'(bus.table_out), 32'h96);
    tick();
    check("held_restart_busy", 32'(bus.busy), 32'h1);
    check("held_restart_x",    32'(bus.x), 32'h0);
    wait_done(lat);
    check("held_latency2", 32'(lat), 32'd25);
    bus.start = 1'b0;
    check("held_table2", 32'(bus.table_out), 32'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
